// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the TDC measurement sequencer.
package tdc_pkg;
  localparam int TDC_N_O          = 6;
  localparam int TDC_SAMPLES_LOG2 = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    SETTLE,
    SAMPLE,
    DONE
  } tdc_seq_state_t;
endpackage

// File: rtl/tdc_stat_acc.sv
// Running min/max/sum of TDC samples; commit copies the post-update working values to the outputs
// in the same cycle, so results are valid alongside the done pulse. No backpressure.
module tdc_stat_acc #(
  parameter int W  = 7,
  parameter int SW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          smp_en,
  input  logic          commit,
  input  logic [W-1:0]  smp,
  output logic [W-1:0]  min_o,
  output logic [W-1:0]  max_o,
  output logic [SW-1:0] sum_o
);
  logic [W-1:0]  min_q, min_d, max_q, max_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  omin_q, omin_d, omax_q, omax_d;
  logic [SW-1:0] osum_q, osum_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    sum_d = sum_q;
    if (clr) begin
      min_d = '1;
      max_d = '0;
      sum_d = '0;
    end else if (smp_en) begin
      if (smp < min_q) min_d = smp;
      if (smp > max_q) max_d = smp;
      sum_d = sum_q + SW'(smp);
    end
    omin_d = commit ? min_d : omin_q;
    omax_d = commit ? max_d : omax_q;
    osum_d = commit ? sum_d : osum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      omin_q <= '0;
      omax_q <= '0;
      osum_q <= '0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      omin_q <= omin_d;
      omax_q <= omax_d;
      osum_q <= osum_d;
    end
  end

  assign min_o = omin_q;
  assign max_o = omax_q;
  assign sum_o = osum_q;
endmodule

// File: rtl/tdc_meas_seq.sv
// Runs 2^SAMPLES_LOG2 launch/capture/settle/sample iterations against the TDC and reports min/max/sum/avg.
// Start-to-done is 1+2^SAMPLES_LOG2*(3+SETTLE_CYC) cycles; start while busy is dropped, abort returns to idle.
module tdc_meas_seq import tdc_pkg::*; #(
  parameter int N_O          = TDC_N_O,
  parameter int SAMPLES_LOG2 = TDC_SAMPLES_LOG2,
  parameter int SETTLE_CYC   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_O:0]                  hw_i,
  output logic                          launch_o,
  output logic                          capture_o,
  output logic                          pg_tog_o,
  output logic                          busy,
  output logic                          done,
  output logic [N_O:0]                  hw_min,
  output logic [N_O:0]                  hw_max,
  output logic [N_O+SAMPLES_LOG2:0]     hw_sum,
  output logic [N_O:0]                  hw_avg
);
  localparam int SW = N_O + 1 + SAMPLES_LOG2;

  tdc_seq_state_t          state_q, state_d;
  logic [3:0]              settle_q, settle_d;
  logic [SAMPLES_LOG2-1:0] count_q, count_d;
  logic launch_q, launch_d, capture_q, capture_d, pg_tog_q, pg_tog_d;
  logic busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LAUNCH;
          count_d = '0;
        end
      end
      LAUNCH:  state_d = CAPTURE;
      CAPTURE: begin
        settle_d = 4'(SETTLE_CYC - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == 4'd0) state_d = SAMPLE;
        else                  settle_d = settle_q - 4'd1;
      end
      SAMPLE: begin
        count_d = count_q + 1'b1;
        state_d = (count_q == {SAMPLES_LOG2{1'b1}}) ? DONE : LAUNCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;

    // Strobes decode the next state so each lands in the cycle its state occupies.
    launch_d  = (state_d == LAUNCH);
    capture_d = (state_d == CAPTURE);
    pg_tog_d  = pg_tog_q ^ (state_d == LAUNCH);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      count_q   <= '0;
      launch_q  <= 1'b0;
      capture_q <= 1'b0;
      pg_tog_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      count_q   <= count_d;
      launch_q  <= launch_d;
      capture_q <= capture_d;
      pg_tog_q  <= pg_tog_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  tdc_stat_acc #(.W(N_O + 1), .SW(SW)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE && state_d == LAUNCH),
    .smp_en (state_q == SAMPLE),
    .commit (state_d == DONE),
    .smp    (hw_i),
    .min_o  (hw_min),
    .max_o  (hw_max),
    .sum_o  (hw_sum)
  );

  assign hw_avg    = hw_sum[SW-1:SAMPLES_LOG2];
  assign launch_o  = launch_q;
  assign capture_o = capture_q;
  assign pg_tog_o  = pg_tog_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_tdc_meas_seq.sv
// Scoreboard bench for tdc_meas_seq at default parameters; outputs sampled on the falling edge.
module tb_tdc_meas_seq;
  localparam int LAT = 97;

  typedef struct {
    logic [6:0]  mn;
    logic [6:0]  mx;
    logic [10:0] sm;
    logic [6:0]  av;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [6:0]  hw_i;
  logic        launch_o, capture_o, pg_tog_o, busy, done;
  logic [6:0]  hw_min, hw_max, hw_avg;
  logic [10:0] hw_sum;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  int   n_launch, n_capture, n_tog, bad_strobe;

  always #5 clk = ~clk;

  tdc_meas_seq #(.N_O(6), .SAMPLES_LOG2(4), .SETTLE_CYC(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hw_i(hw_i),
    .launch_o(launch_o), .capture_o(capture_o), .pg_tog_o(pg_tog_o),
    .busy(busy), .done(done), .hw_min(hw_min), .hw_max(hw_max),
    .hw_sum(hw_sum), .hw_avg(hw_avg)
  );

  // Drives one run; hw_i advances on each launch so every SAMPLE sees one new value.
  task automatic do_run(input int kind, input int base, input bit poke,
                        output int lat, output bit got);
    logic [6:0] vals[16];
    exp_t e;
    int   idx;
    bit   prev_launch, prev_tog;
    e.mn = 7'h7f; e.mx = 7'h00; e.sm = 11'd0;
    for (int i = 0; i < 16; i++) begin
      vals[i] = (kind == 0) ? 7'(base) : 7'(base + i);
      if (vals[i] < e.mn) e.mn = vals[i];
      if (vals[i] > e.mx) e.mx = vals[i];
      e.sm = e.sm + 11'(vals[i]);
    end
    e.av = 7'(int'(e.sm) / 16);
    sb_q.push_back(e);
    n_launch = 0; n_capture = 0; n_tog = 0; bad_strobe = 0;
    prev_launch = 1'b0; prev_tog = pg_tog_o;
    idx = 0; got = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    while (lat < 300) begin
      if (launch_o) begin
        if (idx < 16) hw_i = vals[idx];
        idx++;
        n_launch++;
        if (prev_launch || capture_o) bad_strobe++;
      end
      if (capture_o) begin
        n_capture++;
        if (!prev_launch) bad_strobe++;
      end
      if (pg_tog_o != prev_tog) n_tog++;
      prev_tog = pg_tog_o;
      prev_launch = launch_o;
      start = poke && (lat == 10 || lat == 50 || lat == 96);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb_q.pop_front();
    last_exp = e;
    n_cmp++; if (hw_min !== e.mn) begin n_fail++; $display("FAIL %s hw_min: got %0d want %0d", nm, hw_min, e.mn); end
    n_cmp++; if (hw_max !== e.mx) begin n_fail++; $display("FAIL %s hw_max: got %0d want %0d", nm, hw_max, e.mx); end
    n_cmp++; if (hw_sum !== e.sm) begin n_fail++; $display("FAIL %s hw_sum: got %0d want %0d", nm, hw_sum, e.sm); end
    n_cmp++; if (hw_avg !== e.av) begin n_fail++; $display("FAIL %s hw_avg: got %0d want %0d", nm, hw_avg, e.av); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s post-done: done=%0d busy=%0d want 0/0", nm, done, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; hw_i = 7'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({launch_o, capture_o, pg_tog_o, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset strobes: got %b want 00000", {launch_o, capture_o, pg_tog_o, busy, done});
    end
    n_cmp++;
    if (hw_min !== 7'd0 || hw_max !== 7'd0 || hw_sum !== 11'd0 || hw_avg !== 7'd0) begin
      n_fail++; $display("FAIL reset results: got %0d/%0d/%0d/%0d want 0/0/0/0", hw_min, hw_max, hw_sum, hw_avg);
    end
    last_exp = '{7'd0, 7'd0, 11'd0, 7'd0};
  endtask

  task automatic test_const_strobes();
    int lat; bit got;
    do_run(0, 32, 1'b0, lat, got);
    n_cmp++; if (!got || lat != LAT) begin n_fail++; $display("FAIL const latency: got %0d (done=%0d) want %0d", lat, got, LAT); end
    n_cmp++; if (n_launch != 16 || n_capture != 16) begin n_fail++; $display("FAIL strobe count: launch %0d capture %0d want 16/16", n_launch, n_capture); end
    n_cmp++; if (bad_strobe != 0) begin n_fail++; $display("FAIL strobe spacing: got %0d bad want 0", bad_strobe); end
    n_cmp++; if (n_tog != 16 || pg_tog_o !== 1'b0) begin n_fail++; $display("FAIL pg_tog: toggles %0d level %0d want 16/0", n_tog, pg_tog_o); end
    check_result("const32");
  endtask

  task automatic test_ramp();
    int lat; bit got;
    do_run(1, 0, 1'b0, lat, got);
    n_cmp++; if (!got || lat != LAT) begin n_fail++; $display("FAIL ramp latency: got %0d want %0d", lat, LAT); end
    check_result("ramp0_15");
  endtask

  task automatic test_wide();
    int lat; bit got;
    do_run(0, 64, 1'b0, lat, got);
    n_cmp++; if (!got) begin n_fail++; $display("FAIL wide: no done within %0d cycles want done", lat); end
    check_result("const64");
  endtask

  task automatic test_abort();
    int n, cyc; bit saw_done; exp_t prior; int lat; bit got;
    prior = last_exp;
    @(negedge clk); start = 1'b1; hw_i = 7'd5;
    @(negedge clk); start = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 200) begin
      if (launch_o) n++;
      if (n < 5) begin @(negedge clk); cyc++; end
    end
    n_cmp++; if (n != 5) begin n_fail++; $display("FAIL abort reach: got %0d launches want 5", n); end
    repeat (2) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort idle: busy=%0d done=%0d want 0/0", busy, done); end
    saw_done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done || busy || launch_o) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_fail++; $display("FAIL abort quiet: got activity want none"); end
    n_cmp++;
    if (hw_min !== prior.mn || hw_max !== prior.mx || hw_sum !== prior.sm) begin
      n_fail++; $display("FAIL abort hold: got %0d/%0d/%0d want %0d/%0d/%0d", hw_min, hw_max, hw_sum, prior.mn, prior.mx, prior.sm);
    end
    do_run(0, 10, 1'b0, lat, got);
    n_cmp++; if (!got || lat != LAT) begin n_fail++; $display("FAIL post-abort latency: got %0d want %0d", lat, LAT); end
    check_result("post_abort");
  endtask

  task automatic test_idle_abort_start();
    bit moved;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    moved = 1'b0;
    repeat (4) begin
      if (busy || launch_o) moved = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (moved) begin n_fail++; $display("FAIL abort+start idle: got run started want none"); end
  endtask

  task automatic test_rst_mid();
    int cyc; bit saw;
    @(negedge clk); start = 1'b1; hw_i = 7'd20;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!capture_o && cyc < 50) begin @(negedge clk); cyc++; end
    n_cmp++; if (!capture_o) begin n_fail++; $display("FAIL rst_mid: no capture in %0d cycles want capture", cyc); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++;
    if ({launch_o, capture_o, pg_tog_o, busy, done} !== 5'b0 || hw_sum !== 11'd0 || hw_min !== 7'd0 || hw_max !== 7'd0 || hw_avg !== 7'd0) begin
      n_fail++; $display("FAIL rst_mid outputs: got %b sum %0d min %0d max %0d want zeros", {launch_o, capture_o, pg_tog_o, busy, done}, hw_sum, hw_min, hw_max);
    end
    saw = 1'b0;
    repeat (110) begin @(negedge clk); if (done || busy) saw = 1'b1; end
    n_cmp++; if (saw) begin n_fail++; $display("FAIL rst_mid quiet: got activity want none"); end
    last_exp = '{7'd0, 7'd0, 11'd0, 7'd0};
  endtask

  task automatic test_busy_start();
    int lat; bit got;
    do_run(1, 3, 1'b1, lat, got);
    n_cmp++; if (!got || lat != LAT) begin n_fail++; $display("FAIL busy start latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (n_launch != 16 || pg_tog_o !== 1'b0) begin n_fail++; $display("FAIL busy start launches: got %0d tog %0d want 16/0", n_launch, pg_tog_o); end
    check_result("busy_start");
  endtask

  task automatic test_back_to_back();
    int lat; bit got;
    do_run(1, 100, 1'b0, lat, got);
    check_result("b2b_a");
    do_run(0, 127, 1'b0, lat, got);
    n_cmp++; if (!got || lat != LAT) begin n_fail++; $display("FAIL b2b latency: got %0d want %0d", lat, LAT); end
    check_result("b2b_b");
  endtask

  initial begin
    test_reset();
    test_const_strobes();
    test_ramp();
    test_wide();
    test_abort();
    test_idle_abort_start();
    test_rst_mid();
    test_busy_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
